// File: rtl/dcm_clkgen_prog_engine.sv
// Serial PROGEN/PROGDATA programmer for DCM_CLKGEN, with PROGDONE handshake, timeout and M/D readback.
// Optional `DCM_PROG_RANGE_CHECK_EN rejects out-of-range M/D at accept instead of truncating them.
module dcm_clkgen_prog_engine #(
  parameter int MD_WIDTH       = 8,
  parameter int GAP_CYCLES     = 5,
  parameter int BLANK_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int M_DEFAULT      = 42,
  parameter int D_DEFAULT      = 25
) (
  input  logic              okClk,
  input  logic              reset,
  input  logic [MD_WIDTH:0] M,
  input  logic [MD_WIDTH:0] D,
  input  logic              prog_trigger,
  input  logic              prog_done_in,
  output logic              prog_en,
  output logic              prog_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [MD_WIDTH:0] M_active,
  output logic [MD_WIDTH:0] D_active
);
  localparam int CMAX = (MD_WIDTH > GAP_CYCLES) ? MD_WIDTH : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [MD_WIDTH-1:0] ONE = MD_WIDTH'(1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] LOAD_D    = 4'd1;
  localparam logic [3:0] SHIFT_D   = 4'd2;
  localparam logic [3:0] GAP1      = 4'd3;
  localparam logic [3:0] LOAD_M    = 4'd4;
  localparam logic [3:0] SHIFT_M   = 4'd5;
  localparam logic [3:0] GAP2      = 4'd6;
  localparam logic [3:0] GO        = 4'd7;
  localparam logic [3:0] WAIT_DONE = 4'd8;
  localparam logic [3:0] REARM     = 4'd9;
`ifdef DCM_PROG_RANGE_CHECK_EN
  localparam logic [3:0]        REJECT = 4'd10;
  localparam logic [MD_WIDTH:0] MIN_M  = (MD_WIDTH+1)'(2);
  localparam logic [MD_WIDTH:0] MAX_V  = {1'b1, {MD_WIDTH{1'b0}}};
`endif

  logic [3:0]          state;
  logic [CW-1:0]       cnt;
  logic [TW-1:0]       wcnt;
  logic [MD_WIDTH-1:0] dsh, msh;
  logic [MD_WIDTH:0]   m_snap, d_snap;

  // Each edge registers the drive for the current state/count, so outputs trail the state by one cycle.
  always_ff @(posedge okClk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wcnt      <= '0;
      dsh       <= '0;
      msh       <= '0;
      m_snap    <= '0;
      d_snap    <= '0;
      prog_en   <= 1'b0;
      prog_data <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      M_active  <= (MD_WIDTH+1)'(M_DEFAULT);
      D_active  <= (MD_WIDTH+1)'(D_DEFAULT);
    end else begin
      prog_en   <= 1'b0;
      prog_data <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (prog_trigger) begin
          m_snap <= M;
          d_snap <= D;
          msh    <= M[MD_WIDTH-1:0] - ONE;
          dsh    <= D[MD_WIDTH-1:0] - ONE;
          busy   <= 1'b1;
          error  <= 1'b0;
          cnt    <= '0;
`ifdef DCM_PROG_RANGE_CHECK_EN
          state  <= (M < MIN_M || M > MAX_V || D == '0 || D > MAX_V) ? REJECT : LOAD_D;
`else
          state  <= LOAD_D;
`endif
        end
        LOAD_D: begin
          prog_en   <= 1'b1;
          prog_data <= (cnt == '0);
          if (cnt == CW'(1)) begin cnt <= '0; state <= SHIFT_D; end
          else cnt <= cnt + 1'b1;
        end
        SHIFT_D: begin
          prog_en   <= 1'b1;
          prog_data <= dsh[0];
          dsh       <= dsh >> 1;
          if (cnt == CW'(MD_WIDTH-1)) begin cnt <= '0; state <= GAP1; end
          else cnt <= cnt + 1'b1;
        end
        GAP1: begin
          if (cnt == CW'(GAP_CYCLES-1)) begin cnt <= '0; state <= LOAD_M; end
          else cnt <= cnt + 1'b1;
        end
        LOAD_M: begin
          prog_en   <= 1'b1;
          prog_data <= 1'b1;
          if (cnt == CW'(1)) begin cnt <= '0; state <= SHIFT_M; end
          else cnt <= cnt + 1'b1;
        end
        SHIFT_M: begin
          prog_en   <= 1'b1;
          prog_data <= msh[0];
          msh       <= msh >> 1;
          if (cnt == CW'(MD_WIDTH-1)) begin cnt <= '0; state <= GAP2; end
          else cnt <= cnt + 1'b1;
        end
        GAP2: begin
          if (cnt == CW'(GAP_CYCLES-1)) begin cnt <= '0; state <= GO; end
          else cnt <= cnt + 1'b1;
        end
        GO: begin
          prog_en <= 1'b1;
          wcnt    <= TW'(1);
          state   <= WAIT_DONE;
        end
        // wcnt counts edges since GO; success is checked first so it wins over a same-cycle timeout.
        WAIT_DONE: begin
          if (prog_done_in && wcnt > TW'(BLANK_CYCLES)) begin
            M_active <= m_snap;
            D_active <= d_snap;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= REARM;
          end else if (wcnt == TW'(TIMEOUT_CYCLES)) begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= REARM;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
`ifdef DCM_PROG_RANGE_CHECK_EN
        REJECT: begin
          error <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= REARM;
        end
`endif
        REARM: if (!prog_trigger) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcm_clkgen_prog_engine.sv
// Self-checking bench: directed vector table, random vectors and reset/range corner cases vs. a queue-based model.
module tb_dcm_clkgen_prog_engine;
  localparam int MW    = 8;
  localparam int GAP   = 5;
  localparam int BLANK = 2;
  localparam int TMO   = 1024;
  localparam int GO_K  = 2*MW + 2*GAP + 5;

  logic          okClk = 1'b0;
  logic          reset, prog_trigger, prog_done_in;
  logic          prog_en, prog_data, busy, done, error;
  logic [MW:0]   M, D, M_active, D_active;

  int n_chk  = 0;
  int n_fail = 0;
  int ref_m  = 42;
  int ref_d  = 25;

  dcm_clkgen_prog_engine dut (
    .okClk(okClk), .reset(reset), .M(M), .D(D),
    .prog_trigger(prog_trigger), .prog_done_in(prog_done_in),
    .prog_en(prog_en), .prog_data(prog_data), .busy(busy), .done(done), .error(error),
    .M_active(M_active), .D_active(D_active)
  );

  always #5 okClk = ~okClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge okClk); #1;
  endtask

  // One full request. delay = edges after GO at which prog_done_in is first sampled high (0 = never).
  task automatic run(input string tag, input int m, input int d, input int delay, input int hold,
                     input int chg_k, input int chg_m);
    logic [1:0] q[$];
    bit rej;
    int dm1, mm1, done_k, first_done, n_done, trace_bad, busy_bad, err_bad, limit, ok;
    logic [1:0] e;
    rej = 1'b0;
`ifdef DCM_PROG_RANGE_CHECK_EN
    rej = (m < 2) || (m > (1 << MW)) || (d < 1) || (d > (1 << MW));
`endif
    dm1 = (d - 1) & ((1 << MW) - 1);
    mm1 = (m - 1) & ((1 << MW) - 1);
    if (!rej) begin
      q.push_back(2'b11); q.push_back(2'b10);
      for (int i = 0; i < MW; i++) q.push_back({1'b1, 1'(dm1 >> i)});
      for (int i = 0; i < GAP; i++) q.push_back(2'b00);
      q.push_back(2'b11); q.push_back(2'b11);
      for (int i = 0; i < MW; i++) q.push_back({1'b1, 1'(mm1 >> i)});
      for (int i = 0; i < GAP; i++) q.push_back(2'b00);
      q.push_back(2'b10);
    end
    ok = !rej && delay != 0;
    if (rej)             done_k = 1;
    else if (delay == 0) done_k = GO_K + TMO;
    else                 done_k = GO_K + ((delay > BLANK) ? delay : BLANK + 1);
    limit = ((hold > done_k) ? hold : done_k) + 3;

    M = (MW+1)'(m); D = (MW+1)'(d); prog_trigger = 1'b1;
    tick();                                   // accept edge
    if (hold == 0) prog_trigger = 1'b0;
    first_done = 0; n_done = 0; trace_bad = 0; busy_bad = 0; err_bad = 0;
    for (int k = 1; k <= limit; k++) begin
      tick();
      e = (k <= q.size()) ? q[k-1] : 2'b00;
      if ({prog_en, prog_data} !== e) begin
        if (trace_bad == 0) $display("  %s: drive differs at cycle %0d: got %b expected %b", tag, k, {prog_en, prog_data}, e);
        trace_bad++;
      end
      if (done === 1'b1) begin n_done++; if (first_done == 0) first_done = k; end
      if (busy !== (k < done_k)) busy_bad++;
      if (error !== ((k >= done_k) ? !ok : 1'b0)) err_bad++;
      if (delay > 0 && k == GO_K + delay - 1) prog_done_in = 1'b1;
      if (k == hold) prog_trigger = 1'b0;
      if (k == chg_k) M = (MW+1)'(chg_m);
    end
    prog_done_in = 1'b0;
    if (ok) begin ref_m = m; ref_d = d; end
    check({tag, " drive trace errors"}, trace_bad, 0);
    check({tag, " done cycle"}, first_done, done_k);
    check({tag, " done pulses"}, n_done, 1);
    check({tag, " busy errors"}, busy_bad, 0);
    check({tag, " error flag errors"}, err_bad, 0);
    check({tag, " M_active"}, M_active, ref_m);
    check({tag, " D_active"}, D_active, ref_d);
  endtask

  typedef struct {
    string name;
    int m, d, delay, hold, chg_k, chg_m;
    int exp_m, exp_d, exp_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{"timeout",   28,  25,  0,   0, 0,  0,  42,  25, 1};
    vt[1] = '{"held_trig", 28,  25, 10, 100, 0,  0,  28,  25, 0};
    vt[2] = '{"blank_edge",56,  10,  3,   0, 0,  0,  56,  10, 0};
    vt[3] = '{"m_change",  28,  25,  2,   0, 5, 56,  28,  25, 0};
    vt[4] = '{"max_md",   256, 256, 10,   0, 0,  0, 256, 256, 0};
    vt[5] = '{"min_md",     2,   1,  1,   0, 0,  0,   2,   1, 0};
`ifdef DCM_PROG_RANGE_CHECK_EN
    vt[6] = '{"m_one",      1,  25, 10,   0, 0,  0,   2,   1, 1};
`else
    vt[6] = '{"m_one",      1,  25, 10,   0, 0,  0,   1,  25, 0};
`endif

    reset = 1'b1; prog_trigger = 1'b0; prog_done_in = 1'b0; M = '0; D = '0;
    repeat (3) tick();
    check("reset prog_en",   prog_en,   0);
    check("reset prog_data", prog_data, 0);
    check("reset busy",      busy,      0);
    check("reset done",      done,      0);
    check("reset error",     error,     0);
    check("reset M_active",  M_active,  42);
    check("reset D_active",  D_active,  25);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run(vt[i].name, vt[i].m, vt[i].d, vt[i].delay, vt[i].hold, vt[i].chg_k, vt[i].chg_m);
      check({vt[i].name, " table M_active"}, M_active, vt[i].exp_m);
      check({vt[i].name, " table D_active"}, D_active, vt[i].exp_d);
      check({vt[i].name, " table error"},    error,    vt[i].exp_err);
    end

    run("wrap_257", 257, 25, 10, 0, 0, 0);

    for (int r = 0; r < 6; r++)
      run("random", $urandom_range(256, 2), $urandom_range(256, 1), $urandom_range(40, 1), 0,
          $urandom_range(30, 1), $urandom_range(511, 0));

    // Reset landing in SHIFT_M must abort without touching M_active.
    M = 9'd100; D = 9'd50; prog_trigger = 1'b1;
    tick();
    prog_trigger = 1'b0;
    repeat (20) tick();
    check("pre-reset prog_en", prog_en, 1);
    reset = 1'b1;
    tick();
    check("midreset prog_en",  prog_en,  0);
    check("midreset busy",     busy,     0);
    check("midreset done",     done,     0);
    check("midreset M_active", M_active, 42);
    check("midreset D_active", D_active, 25);
    reset = 1'b0; ref_m = 42; ref_d = 25;
    repeat (2) tick();
    run("post_reset", 28, 25, 10, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
